cv32e40p_x_rsp_writeback: RTL and testbench

CV32E40P_X_RSP_WRITEBACK -- requirements
Module: cv32e40p_x_rsp_writeback

---
 rtl/cv32e40p_x_rsp_writeback.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_x_rsp_writeback.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_rsp_writeback.sv
// X-interface result writeback: buffers accelerator response beats in a small FIFO,
// merges them onto the register-file write port and tracks registers awaiting results.
module cv32e40p_x_rsp_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        issue_dual_i,
    input  logic        x_p_valid_i,
    output logic        x_p_ready_o,
    input  logic [4:0]  x_p_rd_i,
    input  logic [31:0] x_p_data_i,
    input  logic        x_p_dualwb_i,
    input  logic        x_p_error_i,
    input  logic        core_wb_valid_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] rd_pending_o,
    output logic        err_valid_o,
    output logic [4:0]  err_rd_o,
    output logic        dual_open_o
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

    logic [4:0]  rd_mem_r   [0:3];
    logic [31:0] data_mem_r [0:3];
    logic        err_mem_r  [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;
    logic [31:0] pending_r;
    logic        dual_open_r;
    logic [4:0]  prev_rd_r;

    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        push_err_s;
    logic [4:0]  head_rd_s;
    logic [31:0] head_data_s;
    logic        head_err_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] pending_nxt_s;

    // Handshake and pop decision; nothing moves while reset is asserted.
    always_comb begin
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == 3'd0);
        head_rd_s   = rd_mem_r[rd_ptr_r];
        head_data_s = data_mem_r[rd_ptr_r];
        head_err_s  = err_mem_r[rd_ptr_r];
        push_s      = rst_ni && x_p_valid_i && !full_s;
        pop_s       = rst_ni && !empty_s && (head_err_s || !core_wb_valid_i);
        // Second beat of a dual pair must target prev_rd+1, otherwise it is a protocol error.
        push_err_s  = x_p_error_i || (dual_open_r && (x_p_rd_i != (prev_rd_r + 5'd1)));
    end

    assign x_p_ready_o  = !full_s;
    assign rd_pending_o = pending_r;
    assign dual_open_o  = dual_open_r;

    // Register-file and error-report outputs driven straight from the popped head.
    always_comb begin
        if (pop_s && !head_err_s) begin
            rf_we_o     = (head_rd_s != 5'd0);
            rf_waddr_o  = head_rd_s;
            rf_wdata_o  = head_data_s;
            err_valid_o = 1'b0;
            err_rd_o    = 5'd0;
        end else if (pop_s) begin
            rf_we_o     = 1'b0;
            rf_waddr_o  = 5'd0;
            rf_wdata_o  = 32'd0;
            err_valid_o = 1'b1;
            err_rd_o    = head_rd_s;
        end else begin
            rf_we_o     = 1'b0;
            rf_waddr_o  = 5'd0;
            rf_wdata_o  = 32'd0;
            err_valid_o = 1'b0;
            err_rd_o    = 5'd0;
        end
    end

    // Scoreboard update: a set in the same cycle overrides a clear, x0 never pends.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (issue_valid_i) begin
            set_mask_s[issue_rd_i] = 1'b1;
            if (issue_dual_i) begin
                set_mask_s[issue_rd_i + 5'd1] = 1'b1;
            end else begin
                set_mask_s[issue_rd_i] = 1'b1;
            end
        end else begin
            set_mask_s = 32'd0;
        end
        if (pop_s) begin
            clr_mask_s[head_rd_s] = 1'b1;
        end else begin
            clr_mask_s = 32'd0;
        end
        pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // Control state: pointers, occupancy, scoreboard and dual-pair tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            pending_r   <= 32'd0;
            dual_open_r <= 1'b0;
            prev_rd_r   <= 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r    <= (wr_ptr_r == LAST_C) ? 2'd0 : wr_ptr_r + 2'd1;
                dual_open_r <= !dual_open_r && x_p_dualwb_i;
                prev_rd_r   <= x_p_rd_i;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_C) ? 2'd0 : rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
            pending_r <= pending_nxt_s;
        end
    end

    // Entry storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= x_p_rd_i;
            data_mem_r[wr_ptr_r] <= x_p_data_i;
            err_mem_r[wr_ptr_r]  <= push_err_s;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_rsp_writeback.sv
// Self-checking bench for cv32e40p_x_rsp_writeback: directed scenarios followed by
// random traffic, compared each cycle against a queue-based reference model.
module tb_cv32e40p_x_rsp_writeback;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_dual_i;
    logic        x_p_valid_i;
    logic        x_p_ready_o;
    logic [4:0]  x_p_rd_i;
    logic [31:0] x_p_data_i;
    logic        x_p_dualwb_i;
    logic        x_p_error_i;
    logic        core_wb_valid_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] rd_pending_o;
    logic        err_valid_o;
    logic [4:0]  err_rd_o;
    logic        dual_open_o;

    cv32e40p_x_rsp_writeback #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_i      (issue_rd_i),
        .issue_dual_i    (issue_dual_i),
        .x_p_valid_i     (x_p_valid_i),
        .x_p_ready_o     (x_p_ready_o),
        .x_p_rd_i        (x_p_rd_i),
        .x_p_data_i      (x_p_data_i),
        .x_p_dualwb_i    (x_p_dualwb_i),
        .x_p_error_i     (x_p_error_i),
        .core_wb_valid_i (core_wb_valid_i),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .rd_pending_o    (rd_pending_o),
        .err_valid_o     (err_valid_o),
        .err_rd_o        (err_rd_o),
        .dual_open_o     (dual_open_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } beat_t;

    beat_t       q[$];
    logic [31:0] m_pend;
    bit          m_dual;
    logic [4:0]  m_prev;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cycle = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s cycle %0d: observed 0x%08h expected 0x%08h", tag, cycle, obs, exp);
    endtask

    task automatic idle();
        issue_valid_i   = 1'b0;
        issue_rd_i      = 5'd0;
        issue_dual_i    = 1'b0;
        x_p_valid_i     = 1'b0;
        x_p_rd_i        = 5'd0;
        x_p_data_i      = 32'd0;
        x_p_dualwb_i    = 1'b0;
        x_p_error_i     = 1'b0;
        core_wb_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [4:0] rd, input logic [31:0] data, input logic dual, input logic err);
        x_p_valid_i  = 1'b1;
        x_p_rd_i     = rd;
        x_p_data_i   = data;
        x_p_dualwb_i = dual;
        x_p_error_i  = err;
    endtask

    // One clock: compare outputs against the model at the falling edge, then advance the model.
    task automatic step();
        bit          pop_e;
        bit          push_e;
        bit          herr;
        logic [4:0]  hrd;
        logic [31:0] hdata;
        beat_t       b;
        @(negedge clk_i);
        herr  = 1'b0;
        hrd   = 5'd0;
        hdata = 32'd0;
        if (q.size() > 0) begin
            hrd   = q[0].rd;
            hdata = q[0].data;
            herr  = q[0].err;
        end
        pop_e  = rst_ni && (q.size() > 0) && (herr || !core_wb_valid_i);
        push_e = rst_ni && x_p_valid_i && (q.size() < DEPTH);
        chk("ready",   {31'd0, x_p_ready_o}, {31'd0, q.size() < DEPTH});
        chk("rf_we",   {31'd0, rf_we_o}, {31'd0, pop_e && !herr && hrd != 5'd0});
        chk("waddr",   {27'd0, rf_waddr_o}, {27'd0, (pop_e && !herr) ? hrd : 5'd0});
        chk("wdata",   rf_wdata_o, (pop_e && !herr) ? hdata : 32'd0);
        chk("err_vld", {31'd0, err_valid_o}, {31'd0, pop_e && herr});
        chk("err_rd",  {27'd0, err_rd_o}, {27'd0, (pop_e && herr) ? hrd : 5'd0});
        chk("pending", rd_pending_o, m_pend);
        chk("dual",    {31'd0, dual_open_o}, {31'd0, m_dual});
        @(posedge clk_i);
        if (!rst_ni) begin
            q.delete();
            m_pend = 32'd0;
            m_dual = 1'b0;
            m_prev = 5'd0;
        end else begin
            if (pop_e) begin
                m_pend[hrd] = 1'b0;
                void'(q.pop_front());
            end
            if (push_e) begin
                b.rd   = x_p_rd_i;
                b.data = x_p_data_i;
                b.err  = x_p_error_i || (m_dual && (x_p_rd_i != 5'(m_prev + 5'd1)));
                q.push_back(b);
                m_dual = !m_dual && x_p_dualwb_i;
                m_prev = x_p_rd_i;
            end
            if (issue_valid_i) begin
                m_pend[issue_rd_i] = 1'b1;
                if (issue_dual_i) m_pend[5'(issue_rd_i + 5'd1)] = 1'b1;
            end
            m_pend[0] = 1'b0;
        end
        cycle++;
        #1;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        q.delete();
        m_pend = 32'd0;
        m_dual = 1'b0;
        m_prev = 5'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("rst_ready", {31'd0, x_p_ready_o}, 32'd1);
        chk("rst_pend",  rd_pending_o, 32'd0);
        chk("rst_we",    {31'd0, rf_we_o}, 32'd0);
        step();

        // Single writeback of rd 5.
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        step(); idle();
        chk("iss5_pend", rd_pending_o, 32'h0000_0020);
        beat(5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(); idle();
        chk("wr5_we",    {31'd0, rf_we_o}, 32'd1);
        chk("wr5_addr",  {27'd0, rf_waddr_o}, 32'd5);
        chk("wr5_data",  rf_wdata_o, 32'hDEAD_BEEF);
        step();
        chk("wr5_pend",  rd_pending_o, 32'd0);

        // Three beats against a busy core port: FIFO fills, third beat stalls.
        core_wb_valid_i = 1'b1;
        beat(5'd1, 32'h1111_1111, 1'b0, 1'b0); step();
        beat(5'd2, 32'h2222_2222, 1'b0, 1'b0); step();
        beat(5'd3, 32'h3333_3333, 1'b0, 1'b0); step();
        chk("full_ready", {31'd0, x_p_ready_o}, 32'd0);
        chk("full_we",    {31'd0, rf_we_o}, 32'd0);
        core_wb_valid_i = 1'b0;
        step();
        x_p_valid_i = 1'b0;
        step(); step(); step();

        // Error beat drains even while the core owns the write port.
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step(); idle();
        core_wb_valid_i = 1'b1;
        beat(5'd7, 32'h0BAD_0BAD, 1'b0, 1'b1);
        step(); x_p_valid_i = 1'b0;
        chk("err7_vld", {31'd0, err_valid_o}, 32'd1);
        chk("err7_rd",  {27'd0, err_rd_o}, 32'd7);
        chk("err7_we",  {31'd0, rf_we_o}, 32'd0);
        step();
        chk("err7_pend",  rd_pending_o, 32'd0);
        chk("err7_pulse", {31'd0, err_valid_o}, 32'd0);
        idle();

        // Dual issue wrapping from x31 to x0, then a legal pair 31/0.
        issue_valid_i = 1'b1; issue_rd_i = 5'd31; issue_dual_i = 1'b1;
        step(); idle();
        chk("dual31_pend", rd_pending_o, 32'h8000_0000);
        beat(5'd31, 32'hAAAA_0031, 1'b1, 1'b0); step();
        chk("dual31_open", {31'd0, dual_open_o}, 32'd1);
        beat(5'd0, 32'hAAAA_0000, 1'b0, 1'b0); step(); x_p_valid_i = 1'b0;
        chk("dual0_we",  {31'd0, rf_we_o}, 32'd0);
        chk("dual0_err", {31'd0, err_valid_o}, 32'd0);
        step(); step();

        // Broken pair 4 -> 9 flags the second entry.
        beat(5'd4, 32'h4444_4444, 1'b1, 1'b0); step();
        beat(5'd9, 32'h9999_9999, 1'b0, 1'b0); step(); x_p_valid_i = 1'b0;
        chk("pair_err_vld", {31'd0, err_valid_o}, 32'd1);
        chk("pair_err_rd",  {27'd0, err_rd_o}, 32'd9);
        step(); step();

        // Reset with two entries queued and a beat on the bus.
        core_wb_valid_i = 1'b1;
        issue_valid_i = 1'b1; issue_rd_i = 5'd12;
        beat(5'd12, 32'hC0C0_0012, 1'b0, 1'b0); step(); issue_valid_i = 1'b0;
        beat(5'd13, 32'hC0C0_0013, 1'b0, 1'b0); step();
        rst_ni = 1'b0; core_wb_valid_i = 1'b0;
        beat(5'd14, 32'hC0C0_0014, 1'b0, 1'b0);
        step();
        rst_ni = 1'b1; idle();
        chk("rst2_ready", {31'd0, x_p_ready_o}, 32'd1);
        chk("rst2_pend",  rd_pending_o, 32'd0);
        chk("rst2_we",    {31'd0, rf_we_o}, 32'd0);
        chk("rst2_dual",  {31'd0, dual_open_o}, 32'd0);
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_ni          = ($urandom_range(0, 63) != 0);
            issue_valid_i   = ($urandom_range(0, 3) == 0);
            issue_rd_i      = 5'($urandom);
            issue_dual_i    = ($urandom_range(0, 3) == 0);
            x_p_valid_i     = ($urandom_range(0, 1) == 1);
            x_p_rd_i        = (m_dual && $urandom_range(0, 3) != 0) ? 5'(m_prev + 5'd1) : 5'($urandom);
            x_p_data_i      = $urandom;
            x_p_dualwb_i    = ($urandom_range(0, 3) == 0);
            x_p_error_i     = ($urandom_range(0, 9) == 0);
            core_wb_valid_i = ($urandom_range(0, 1) == 1);
            step();
        end
        rst_ni = 1'b1; idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
